// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int NPORT = 2;
  localparam int PORT_CORE = 0;
  localparam int PORT_LDR = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way picker, round-robin or fixed priority
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  always_comb gnt = (&req) ? ((rr_en && !last_grant) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and one-shot access sequencer for the data memory
module dmem_arbiter #(
  parameter bit RR = 1'b1,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  import dmem_arb_pkg::*;
  state_t state;
  logic last_grant, owner, we, err, sel, hs, access;
  logic [1:0] gnt;
  logic [ADDR_W-1:0] addr, sel_addr;
  logic [DATA_W-1:0] wdata, rdata, sel_wdata;
  rr_arb2 u_arb (.req(req_valid), .last_grant(last_grant), .rr_en(RR), .gnt(gnt));
  always_comb begin
    req_ready = (state == ST_IDLE && !rst) ? gnt : 2'b00;
    sel = gnt[1];
    hs = |(req_valid & req_ready);
    sel_addr = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    access = state == ST_ACCESS;
    // strobes are gated by rst so a reset cycle can never commit a write
    mem_read = access && !we && !rst;
    mem_write = access && we && !rst;
    mem_addr = access ? addr : '0;
    mem_wdata = access ? wdata : '0;
    rsp_valid = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    rsp_rdata = rdata;
    rsp_err = err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else if (hs) begin
      owner <= sel;
      last_grant <= sel;
      we <= req_we[sel];
      addr <= sel_addr;
      wdata <= sel_wdata;
      rdata <= '0;
      err <= |sel_addr[1:0];
      state <= (|sel_addr[1:0]) ? ST_RESP : ST_ACCESS;
    end else if (access) begin
      state <= ST_RESP;
      rdata <= we ? '0 : mem_rdata;
    end else if (state == ST_RESP && rsp_ready[owner]) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus, per-cycle reference model and literal checks
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] req_valid = 2'b00, req_we = 2'b00, rsp_ready = 2'b11;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0] req_ready, rsp_valid, req_ready_f, rsp_valid_f;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata, rsp_rdata_f, mem_wdata_f;
  logic rsp_err, mem_read, mem_write, rsp_err_f, mem_read_f, mem_write_f;
  logic [7:0] mem_addr, mem_addr_f;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int n_cmp = 0, n_bad = 0, cyc = 0, n_rd = 0, n_wr = 0;
  int gq[$], gq_f[$];

  dmem_arbiter #(.RR(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  dmem_arbiter #(.RR(1'b0)) dut_f (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_f), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_f), .rsp_err(rsp_err_f), .mem_read(mem_read_f), .mem_write(mem_write_f),
    .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_rdata(32'h0));

  function automatic logic [31:0] init_val(int i);
    return (i == 2) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction
  function automatic logic [1:0] pick(logic [1:0] v, bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk)
    if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_read) n_rd <= n_rd + 1;
    if (mem_write) n_wr <= n_wr + 1;
  end
  always @(negedge clk)
    if (!rst) for (int p = 0; p < 2; p++) begin
      if (req_valid[p] && req_ready[p]) gq.push_back(p);
      if (req_valid[p] && req_ready_f[p]) gq_f.push_back(p);
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: one transaction in flight, timed from its handshake cycle
  initial begin
    bit m_busy, m_last, m_owner, m_we, m_err, at_acc;
    int m_acc, m_rsp, p;
    logic [7:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [1:0] er, ev;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    m_busy = 0; m_last = 1; m_acc = -1; m_rsp = 0; m_owner = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    @(posedge clk iff rst);
    forever begin
      @(negedge clk);
      er = (!m_busy && !rst) ? pick(req_valid, m_last) : 2'b00;
      at_acc = (cyc == m_acc);
      ev = (m_busy && cyc >= m_rsp) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready, er);
      chk("mem_read", mem_read, at_acc && !m_we && !rst);
      chk("mem_write", mem_write, at_acc && m_we && !rst);
      chk("mem_addr", mem_addr, at_acc ? m_addr : 8'h0);
      chk("mem_wdata", mem_wdata, at_acc ? m_wdata : 32'h0);
      chk("rsp_valid", rsp_valid, ev);
      if (ev != 2'b00) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end
      if (rst) begin
        m_busy = 0; m_last = 1; m_acc = -1;
      end else begin
        if (at_acc && m_we) ref_mem[m_addr[7:2]] = m_wdata;
        if (ev != 2'b00 && rsp_ready[m_owner]) m_busy = 0;
        if (|(er & req_valid)) begin
          p = er[1] ? 1 : 0;
          m_busy = 1; m_owner = p[0]; m_last = p[0]; m_we = req_we[p];
          m_addr = req_addr[p*8 +: 8]; m_wdata = req_wdata[p*32 +: 32];
          m_err = m_addr[1:0] != 2'b00;
          m_acc = m_err ? -1 : cyc + 1;
          m_rsp = cyc + (m_err ? 1 : 2);
          m_rdata = (m_err || m_we) ? 32'h0 : ref_mem[m_addr[7:2]];
        end
      end
    end
  end

  task automatic xfer(input int p, input bit we, input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat);
    int t0;
    bit ok;
    t0 = 0; rd = 'x; e = 1'bx; lat = -1;
    @(posedge clk); #1;
    req_valid[p] = 1'b1; req_we[p] = we; req_addr[p*8 +: 8] = a; req_wdata[p*32 +: 32] = wd;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1; t0 = cyc; end
    end
    chk("xfer_handshake", ok, 1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid[p] && rsp_ready[p]) begin ok = 1; lat = cyc - t0; rd = rsp_rdata; e = rsp_err; end
    end
    chk("xfer_response", ok, 1);
  endtask

  task automatic wait_flag(input string nm, input int p, input bit is_rsp);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = is_rsp ? rsp_valid[p] : req_ready[p];
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int lat, r0, w0, g0, gf0;
    req_valid = 2'b11;
    @(posedge clk); @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem", {mem_read, mem_write, mem_addr, mem_wdata}, '0);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0; req_valid = 2'b00;
    r0 = n_rd;
    xfer(0, 1'b0, 8'h08, 32'h0, rd, e, lat);
    chk("rd_latency", lat, 2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", e, 1'b0);
    chk("rd_strobes", n_rd - r0, 1);
    w0 = n_wr;
    xfer(1, 1'b1, 8'h3C, 32'h12345678, rd, e, lat);
    chk("wr_latency", lat, 2);
    chk("wr_rdata", rd, 32'h0);
    chk("wr_strobes", n_wr - w0, 1);
    xfer(1, 1'b0, 8'h3C, 32'h0, rd, e, lat);
    chk("rdback_data", rd, 32'h12345678);
    r0 = n_rd; w0 = n_wr;
    xfer(0, 1'b0, 8'h05, 32'h0, rd, e, lat);
    chk("mis_latency", lat, 1);
    chk("mis_err", e, 1'b1);
    chk("mis_rdata", rd, 32'h0);
    chk("mis_strobes", (n_rd - r0) + (n_wr - w0), 0);
    // backpressure on port 1 while port 0 waits
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0; req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[15:8] = 8'h3C;
    wait_flag("bp_handshake", 1, 1'b0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[7:0] = 8'h08;
    wait_flag("bp_response", 1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 2'b10);
      chk("bp_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", req_ready, 2'b00);
    @(negedge clk);
    chk("bp_grant0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    // reset while a response is pending
    #1 rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_addr[7:0] = 8'h08;
    wait_flag("rr_handshake", 0, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_flag("rr_response", 0, 1'b1);
    w0 = n_wr;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 2'b11;
    @(negedge clk);
    chk("rstm_rsp_valid", rsp_valid, 2'b00);
    chk("rstm_rsp_rdata", {rsp_err, rsp_rdata}, 33'h0);
    chk("rstm_req_ready", req_ready, 2'b00);
    chk("rstm_no_write", n_wr - w0, 0);
    xfer(0, 1'b0, 8'h3C, 32'h0, rd, e, lat);
    chk("rstm_next_data", rd, 32'h12345678);
    chk("rstm_next_latency", lat, 2);
    // contention straight after reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    g0 = gq.size(); gf0 = gq_f.size();
    req_valid = 2'b11; req_we = 2'b00; req_addr = 16'h0400;
    repeat (13) @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);
    chk("rr_grant_count", gq.size() - g0 >= 4, 1);
    for (int i = 0; i < 4; i++) chk("rr_grant", (gq.size() > g0 + i) ? gq[g0 + i] : -1, i % 2);
    chk("fp_grant_count", gq_f.size() - gf0 >= 4, 1);
    for (int i = gf0; i < gq_f.size(); i++) chk("fp_grant", gq_f[i], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequential two-port arbiter and access sequencer for the single-cycle data memory (64 × 32-bit words, byte address 8 bits, word index = addr[7:2]). Port 0 serves the core load/store path; port 1 serves the loader/debug path. The block grants one requester at a time, drives the memory's read/write strobes for exactly one cycle per access, registers the read data and returns a handshaked response.

## Interface
- RR, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.
- ADDR_W, default 8: byte address width.
- DATA_W, default 32: data width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit n = port n.
- req_ready  out  2  per-port accept; a handshake is valid && ready in the same cycle.
- req_we  in  2  1 = write, 0 = read.
- req_addr  in  2×ADDR_W  per-port byte address.
- req_wdata  in  2×DATA_W  per-port write data.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_rdata  out  DATA_W  read data for the port holding rsp_valid.
- rsp_err  out  1  misaligned-access flag for the current response.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write data.
- mem_rdata  in  DATA_W  from memory read data; combinational.

## Operation
- FSM has three states:
  - IDLE → ACCESS on a handshake with an aligned address (addr[1:0]==0).
  - IDLE → RESP on a handshake with a misaligned address. The memory is not touched.
  - ACCESS → RESP unconditionally after 1 cycle.
  - RESP → IDLE on rsp_ready of the owning port.
- req_ready is nonzero only in IDLE, and at most one bit is set: the arbitration winner among asserted req_valid bits. It is combinational from state, req_valid and last_grant.
- Arbitration:
  - RR=1: if both ports request, grant the port that is not last_grant; a single requester always wins. last_grant updates on every handshake.
  - RR=0: port 0 always wins.
- On handshake, the block registers owner, we, addr and wdata.
- ACCESS drives from those registers:
  - mem_addr and mem_wdata.
  - mem_read = !we; mem_write = we.
  - For a read, mem_rdata is registered into rsp_rdata at the end of the cycle.
- Outside ACCESS: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. This guarantees exactly one write strobe per write request.
- RESP:
  - rsp_valid[owner]=1; rsp_rdata and rsp_err are held stable until rsp_ready[owner].
  - Writes respond with rsp_rdata=0.
  - Misaligned requests respond with rsp_err=1 and rsp_rdata=0.
- With RR=1, starvation bound: a continuously requesting port is granted within 2 grants.

## Timing
- Reset values: state=IDLE, last_grant=1 (port 0 wins first in RR mode), req_ready=0 in the reset cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, all mem_* = 0.
- Latency: handshake in cycle T; ACCESS in T+1; rsp_valid asserted in T+2.
  - Misaligned requests: rsp_valid in T+1.
- Throughput: one access per 3 cycles minimum. There is no new grant while in ACCESS or RESP.
- rsp_ready held low keeps the FSM in RESP and blocks both ports. req_ready stays 0.
- Simultaneous req_valid on both ports in IDLE: exactly one handshake per cycle; the loser is granted on the next IDLE.
- A request that drops req_valid before ready is never serviced. No state is recorded.
- Reset mid-operation:
  - A write whose ACCESS cycle completed before the reset edge is committed.
  - Any pending response is discarded; rsp_valid=0 after the edge.
  - In the reset cycle itself, all outputs take their reset values from the next edge. During a cycle with rst high, mem_write must not be asserted.

## Structure
- dmem_arb_pkg holds:
  - state enum: ST_IDLE, ST_ACCESS, ST_RESP.
  - constants ADDR_W=8, DATA_W=32, NPORT=2, PORT_CORE=0, PORT_LDR=1.
- Sub-module rr_arb2: combinational 2-way picker.
  - Inputs: req[1:0], last_grant, rr_en.
  - Output: one-hot gnt[1:0].
- Reused by the future instruction-memory loader.

## Test plan
- Single read, port 0, addr=0x08, memory word 2 = 0xDEADBEEF:
  - handshake T; mem_read=1 and mem_addr=0x08 only in T+1.
  - rsp_valid[0] in T+2 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write then read, port 1:
  - write addr=0x3C, wdata=0x12345678: mem_write high for exactly 1 cycle.
  - response rsp_rdata=0.
  - subsequent read of 0x3C returns 0x12345678.
- Contention, RR=1:
  - both ports hold reads continuously after reset: grants alternate 0,1,0,1.
  - RR=0 with the same stimulus: only port 0 granted.
- Misaligned: port 0 reads addr=0x05 → mem_read and mem_write never assert; rsp_valid[0] at T+1 with rsp_err=1, rsp_rdata=0.
- Backpressure: rsp_ready[1]=0 for 5 cycles → rsp_valid[1] and rsp_rdata stable; req_ready=0 both ports; a port-0 request is granted the cycle after release.
- Reset during RESP: rst high for 1 cycle → rsp_valid=0, state=IDLE, mem_write never asserted; the next request is serviced normally.
